// File: rtl/hvsp_op_sequencer.sv
// HVSP multi-frame operation sequencer: issues 1-4 shifter frames, captures the last SDO byte, optional RDY poll.
// Optional macro HVSP_SEQ_ABORT_EN adds op_abort / err_abort.
module hvsp_op_sequencer #(
   parameter int CLK_PER_US      = 24,
   parameter int POLL_TIMEOUT_US = 5000
) (
   input  logic        osc,
   input  logic        rst_n,
   input  logic        op_start,
   input  logic [1:0]  op_nframes,
   input  logic        op_poll,
   input  logic [31:0] op_sdi,
   input  logic [31:0] op_sii,
`ifdef HVSP_SEQ_ABORT_EN
   input  logic        op_abort,
   output logic        err_abort,
`endif
   output logic        busy,
   output logic        done,
   output logic        err_timeout,
   output logic [7:0]  result,
   output logic        shf_req,
   output logic [7:0]  shf_sdi,
   output logic [7:0]  shf_sii,
   input  logic        shf_ack,
   input  logic [10:0] shf_sdo,
   input  logic        sdo_pin
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] ISSUE    = 3'd1;
   localparam logic [2:0] WAIT_ACK = 3'd2;
   localparam logic [2:0] POLL     = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

   logic [2:0]    state;
   logic [1:0]    nf_q;
   logic          poll_q;
   logic [31:0]   sdi_q;
   logic [31:0]   sii_q;
   logic [1:0]    idx;
   logic [PW-1:0] presc;
   logic [15:0]   us_cnt;
   logic          sdo_meta;
   logic          sdo_sync;
   logic          stop_req;
   logic          unused_sdo_lsbs;

   assign unused_sdo_lsbs = ^shf_sdo[2:0];

`ifdef HVSP_SEQ_ABORT_EN
   logic abort_pend;
   assign stop_req = abort_pend | op_abort;
`else
   assign stop_req = 1'b0;
`endif

   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         nf_q        <= '0;
         poll_q      <= 1'b0;
         sdi_q       <= '0;
         sii_q       <= '0;
         idx         <= '0;
         presc       <= '0;
         us_cnt      <= '0;
         sdo_meta    <= 1'b0;
         sdo_sync    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         result      <= '0;
         shf_req     <= 1'b0;
         shf_sdi     <= '0;
         shf_sii     <= '0;
`ifdef HVSP_SEQ_ABORT_EN
         abort_pend  <= 1'b0;
         err_abort   <= 1'b0;
`endif
      end else begin
         sdo_meta <= sdo_pin;
         sdo_sync <= sdo_meta;
         done     <= 1'b0;
`ifdef HVSP_SEQ_ABORT_EN
         if ((state == ISSUE || state == WAIT_ACK) && op_abort)
            abort_pend <= 1'b1;
`endif
         case (state)
            IDLE: begin
               if (op_start) begin
                  nf_q        <= op_nframes;
                  poll_q      <= op_poll;
                  sdi_q       <= op_sdi;
                  sii_q       <= op_sii;
                  idx         <= '0;
                  busy        <= 1'b1;
                  err_timeout <= 1'b0;
`ifdef HVSP_SEQ_ABORT_EN
                  abort_pend  <= 1'b0;
                  err_abort   <= 1'b0;
`endif
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               shf_sdi <= sdi_q[{idx, 3'b000} +: 8];
               shf_sii <= sii_q[{idx, 3'b000} +: 8];
               shf_req <= 1'b1;
               state   <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (shf_ack) begin
                  shf_req <= 1'b0;
                  result  <= shf_sdo[10:3];
                  // A pending abort wins over both further frames and the RDY poll
                  if (stop_req) begin
`ifdef HVSP_SEQ_ABORT_EN
                     err_abort <= 1'b1;
`endif
                     state <= DONE;
                  end else if (idx == nf_q) begin
                     presc  <= PW'(CLK_PER_US - 1);
                     us_cnt <= '0;
                     state  <= poll_q ? POLL : DONE;
                  end else begin
                     idx   <= idx + 2'd1;
                     state <= ISSUE;
                  end
               end
            end
            POLL: begin
               if (sdo_sync) begin
                  state <= DONE;
`ifdef HVSP_SEQ_ABORT_EN
               end else if (op_abort) begin
                  err_abort <= 1'b1;
                  state     <= DONE;
`endif
               end else if (presc == '0) begin
                  presc  <= PW'(CLK_PER_US - 1);
                  us_cnt <= us_cnt + 16'd1;
                  // Leave on the tick that makes the count reach the limit
                  if (us_cnt == 16'(POLL_TIMEOUT_US - 1)) begin
                     err_timeout <= 1'b1;
                     state       <= DONE;
                  end
               end else begin
                  presc <= presc - PW'(1);
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hvsp_op_sequencer.sv
// Self-checking bench for hvsp_op_sequencer with a behavioural shifter and a result/frame scoreboard.
module tb_hvsp_op_sequencer;
   logic        osc = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_start = 1'b0;
   logic [1:0]  op_nframes = '0;
   logic        op_poll = 1'b0;
   logic [31:0] op_sdi = '0;
   logic [31:0] op_sii = '0;
   logic        busy, done, err_timeout, shf_req;
   logic [7:0]  result, shf_sdi, shf_sii;
   logic        shf_ack = 1'b0;
   logic [10:0] shf_sdo = '0;
   logic        sdo_pin = 1'b0;
`ifdef HVSP_SEQ_ABORT_EN
   logic        op_abort = 1'b0;
   logic        err_abort;
`endif

   int n_vec = 0;
   int n_err = 0;
   int req_rises = 0;
   logic req_prev = 1'b0;
   logic [7:0] sdi_exp_q[$];
   logic [7:0] sii_exp_q[$];
   logic [7:0] res_exp_q[$];

   always #5 osc = ~osc;

   hvsp_op_sequencer #(.CLK_PER_US(24), .POLL_TIMEOUT_US(10)) dut (
`ifdef HVSP_SEQ_ABORT_EN
      .op_abort(op_abort),
      .err_abort(err_abort),
`endif
      .osc(osc), .rst_n(rst_n), .op_start(op_start), .op_nframes(op_nframes),
      .op_poll(op_poll), .op_sdi(op_sdi), .op_sii(op_sii), .busy(busy), .done(done),
      .err_timeout(err_timeout), .result(result), .shf_req(shf_req), .shf_sdi(shf_sdi),
      .shf_sii(shf_sii), .shf_ack(shf_ack), .shf_sdo(shf_sdo), .sdo_pin(sdo_pin)
   );

   always @(negedge osc) begin
      if (shf_req && !req_prev) req_rises++;
      req_prev = shf_req;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_op(input logic [1:0] nf, input logic poll, input logic [31:0] sdi,
                           input logic [31:0] sii, input int nexp);
      for (int k = 0; k < nexp; k++) begin
         sdi_exp_q.push_back(sdi[8*k +: 8]);
         sii_exp_q.push_back(sii[8*k +: 8]);
      end
      op_nframes = nf; op_poll = poll; op_sdi = sdi; op_sii = sii; op_start = 1'b1;
      @(negedge osc);
      op_start = 1'b0;
      op_sdi = $urandom; op_sii = $urandom; op_nframes = 2'($urandom); op_poll = 1'($urandom);
   endtask

   // inj_kind: 1 = stray op_start, 2 = op_abort, pulsed on cycle 3 of frame inj_frame
   task automatic serve(input int nfr, input int delay, input logic [10:0] last_sdo,
                        input int inj_frame, input int inj_kind);
      logic [7:0] e_sdi, e_sii;
      logic [10:0] sdo;
      logic stable;
      int w;
      for (int f = 0; f < nfr; f++) begin
         w = 0;
         while (!shf_req && w < 20) begin @(negedge osc); w++; end
         n_vec++;
         if (!shf_req) begin
            n_err++;
            $display("FAIL req_wait frame %0d: shf_req=0 after %0d cycles, required 1", f, w);
            return;
         end
         e_sdi = (sdi_exp_q.size() > 0) ? sdi_exp_q.pop_front() : 8'hxx;
         e_sii = (sii_exp_q.size() > 0) ? sii_exp_q.pop_front() : 8'hxx;
         n_vec++;
         if (shf_sdi !== e_sdi || shf_sii !== e_sii) begin
            n_err++;
            $display("FAIL frame_data %0d: sdi=%h sii=%h, required sdi=%h sii=%h",
                     f, shf_sdi, shf_sii, e_sdi, e_sii);
         end
         stable = 1'b1;
         for (int c = 0; c < delay; c++) begin
            if (f == inj_frame && c == 3) begin
               if (inj_kind == 1) begin
                  op_start = 1'b1; op_nframes = 2'd3; op_sii = 32'hFFFF_FFFF;
               end
`ifdef HVSP_SEQ_ABORT_EN
               if (inj_kind == 2) op_abort = 1'b1;
`endif
            end
            @(negedge osc);
            op_start = 1'b0;
`ifdef HVSP_SEQ_ABORT_EN
            op_abort = 1'b0;
`endif
            if (!shf_req || shf_sdi !== e_sdi || shf_sii !== e_sii) stable = 1'b0;
         end
         n_vec++;
         if (!stable) begin
            n_err++;
            $display("FAIL req_hold frame %0d: stable=0, required 1", f);
         end
         sdo = (f == nfr - 1) ? last_sdo : 11'($urandom);
         if (f == nfr - 1) res_exp_q.push_back(last_sdo[10:3]);
         shf_ack = 1'b1; shf_sdo = sdo;
         @(negedge osc);
         shf_ack = 1'b0; shf_sdo = 11'($urandom);
         n_vec++;
         if (shf_req !== 1'b0) begin
            n_err++;
            $display("FAIL req_drop frame %0d: shf_req=%b, required 0", f, shf_req);
         end
      end
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < limit) begin @(negedge osc); cyc++; end
   endtask

   task automatic check_end(input string name);
      logic [7:0] e;
      e = (res_exp_q.size() > 0) ? res_exp_q.pop_front() : 8'hxx;
      n_vec++;
      if (done !== 1'b1 || result !== e || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_end: done=%b result=%h busy=%b, required done=1 result=%h busy=0",
                  name, done, result, busy, e);
      end
      @(negedge osc);
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL %s_pulse: done=%b one cycle later, required 0", name, done);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge osc);
      n_vec++;
      if ({busy, done, err_timeout, result, shf_req, shf_sdi, shf_sii} !== '0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b err=%b res=%h req=%b sdi=%h sii=%h, required all 0",
                  busy, done, err_timeout, result, shf_req, shf_sdi, shf_sii);
      end
      rst_n = 1'b1;
      @(negedge osc);
   endtask

   task automatic test_single_frame;
      int cyc;
      start_op(2'd0, 1'b0, 32'h0000_0008, 32'h0000_004C, 1);
      n_vec++;
      if (shf_req !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL start_latency: req=%b busy=%b, required req=0 busy=1", shf_req, busy);
      end
      serve(1, 40, 11'h4A8, -1, 0);
      wait_done(10, cyc);
      n_vec++;
      if (cyc + 1 != 2) begin
         n_err++;
         $display("FAIL ack_to_done: %0d cycles, required 2", cyc + 1);
      end
      n_vec++;
      if (result !== 8'h95) begin
         n_err++;
         $display("FAIL single_result: result=%h, required 95", result);
      end
      check_end("single");
   endtask

   task automatic test_four_frames;
      int r0, cyc;
      r0 = req_rises;
      start_op(2'd3, 1'b0, 32'h0000_0010, 32'h6C64_6C4C, 4);
      serve(4, 5, 11'h3C7, -1, 0);
      wait_done(10, cyc);
      check_end("four");
      repeat (4) @(negedge osc);
      n_vec++;
      if (req_rises - r0 != 4) begin
         n_err++;
         $display("FAIL four_req_count: %0d requests, required 4", req_rises - r0);
      end
   endtask

   task automatic test_poll_ok;
      int cyc;
      logic quiet;
      start_op(2'd0, 1'b1, 32'h0000_00A5, 32'h0000_0033, 1);
      serve(1, 8, 11'h155, -1, 0);
      quiet = 1'b1;
      repeat (120) begin @(negedge osc); if (done || !busy) quiet = 1'b0; end
      n_vec++;
      if (!quiet) begin
         n_err++;
         $display("FAIL poll_wait: operation ended before RDY, required still busy");
      end
      sdo_pin = 1'b1;
      wait_done(20, cyc);
      n_vec++;
      if (cyc < 3 || cyc > 4) begin
         n_err++;
         $display("FAIL poll_rdy_latency: %0d cycles, required 3..4", cyc);
      end
      n_vec++;
      if (err_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL poll_err: err_timeout=%b, required 0", err_timeout);
      end
      check_end("poll");
      sdo_pin = 1'b0;
      repeat (3) @(negedge osc);
   endtask

   task automatic test_poll_timeout;
      int cyc;
      start_op(2'd0, 1'b1, 32'h0000_0011, 32'h0000_0022, 1);
      serve(1, 10, 11'h7F0, -1, 0);
      wait_done(400, cyc);
      n_vec++;
      if (cyc < 238 || cyc > 242) begin
         n_err++;
         $display("FAIL timeout_latency: %0d cycles after POLL entry, required 238..242", cyc);
      end
      n_vec++;
      if (err_timeout !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_flag: err_timeout=%b, required 1", err_timeout);
      end
      check_end("timeout");
      start_op(2'd0, 1'b0, 32'h0000_0001, 32'h0000_0002, 1);
      n_vec++;
      if (err_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_clear: err_timeout=%b after start, required 0", err_timeout);
      end
      serve(1, 3, 11'h008, -1, 0);
      wait_done(10, cyc);
      check_end("after_timeout");
   endtask

   task automatic test_busy_ignore;
      int r0, cyc;
      r0 = req_rises;
      start_op(2'd1, 1'b0, 32'h0000_5A69, 32'h0000_6C4C, 2);
      serve(2, 12, 11'h2AB, 0, 1);
      wait_done(10, cyc);
      check_end("ignore");
      repeat (5) @(negedge osc);
      n_vec++;
      if (req_rises - r0 != 2 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_start: %0d requests busy=%b, required 2 busy=0", req_rises - r0, busy);
      end
   endtask

   task automatic test_reset_mid_op;
      int w, cyc;
      start_op(2'd1, 1'b0, 32'h0000_1234, 32'h0000_5678, 2);
      w = 0;
      while (!shf_req && w < 20) begin @(negedge osc); w++; end
      repeat (3) @(negedge osc);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (shf_req !== 1'b0 || busy !== 1'b0 || w >= 20) begin
         n_err++;
         $display("FAIL async_reset: req=%b busy=%b, required 0 0", shf_req, busy);
      end
      sdi_exp_q.delete(); sii_exp_q.delete(); res_exp_q.delete();
      @(negedge osc);
      rst_n = 1'b1;
      @(negedge osc);
      start_op(2'd0, 1'b0, 32'h0000_0030, 32'h0000_0068, 1);
      serve(1, 6, 11'h1E5, -1, 0);
      wait_done(10, cyc);
      check_end("post_reset");
   endtask

`ifdef HVSP_SEQ_ABORT_EN
   task automatic test_abort;
      int r0, cyc;
      r0 = req_rises;
      start_op(2'd3, 1'b0, 32'h4433_2211, 32'h6C64_6C4C, 2);
      serve(2, 10, 11'h6D2, 1, 2);
      wait_done(10, cyc);
      n_vec++;
      if (err_abort !== 1'b1) begin
         n_err++;
         $display("FAIL abort_flag: err_abort=%b, required 1", err_abort);
      end
      check_end("abort");
      repeat (6) @(negedge osc);
      n_vec++;
      if (req_rises - r0 != 2) begin
         n_err++;
         $display("FAIL abort_frames: %0d requests, required 2", req_rises - r0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_four_frames();
      test_poll_ok();
      test_poll_timeout();
      test_busy_ignore();
      test_reset_mid_op();
`ifdef HVSP_SEQ_ABORT_EN
      test_abort();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
